ex_mem_skid: RTL
================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ALU result and store data.
REQ-002 Parameter RD_WIDTH, default 5: destination register index width.
REQ-003 Parameter CTRL_WIDTH, default 4: width of the MEM/WB control bundle {reg_write, mem_to_reg, mem_write, mem_read}, MSB to LSB.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 ex_valid_i  in  1: EX stage presents a valid instruction.
REQ-007 ex_ready_o  out  1: block can accept from EX this cycle.
REQ-008 alu_result_i  in  DATA_WIDTH: EX ALU result or memory address.
REQ-009 rd2_data_i  in  DATA_WIDTH: forwarded rs2 value, used as store data.
REQ-010 rd_i  in  RD_WIDTH: destination register index.
REQ-011 control_flow_i  in  CTRL_WIDTH: MEM/WB control bundle.
REQ-012 flush_i  in  1: synchronous pipeline flush.
REQ-013 mem_valid_o  out  1: valid entry presented to MEM.
REQ-014 mem_ready_i  in  1: MEM consumes the presented entry.
REQ-015 alu_result_o, rd2_data_o, rd_o, control_flow_o  out  (widths as inputs): head-entry payload.
REQ-016 occupancy_o  out  2: number of held entries, 0..2.

Function
REQ-017 Accept = ex_valid_i && ex_ready_o; deliver = mem_valid_o && mem_ready_i; both evaluated at the same rising edge.
REQ-018 States: EMPTY (0 entries), ONE (main full), TWO (main + skid full); occupancy_o encodes 0/1/2.
REQ-019 EMPTY: accept -> ONE, with the payload latched into main.
REQ-020 ONE: accept with no deliver -> TWO, with the payload latched into skid. Deliver with no accept -> EMPTY. Accept and deliver together -> stay ONE, with main loaded from the input.
REQ-021 TWO: deliver -> ONE, with skid moved into main. No accept is possible in TWO.
REQ-022 ex_ready_o = 1 in EMPTY and ONE, 0 in TWO; it is a registered signal with no combinational path from mem_ready_i.
REQ-023 mem_valid_o = 1 in ONE and TWO; the payload outputs always reflect main.
REQ-024 Latency: an entry accepted at edge N is presented on mem_valid_o after edge N when the block was EMPTY or the head was delivered at edge N.
REQ-025 Order is strictly FIFO; no entry is dropped or duplicated.
REQ-026 While mem_valid_o && !mem_ready_i, all payload outputs hold stable.
REQ-027 When mem_valid_o = 0, control_flow_o = 0 (bubble) and rd_o = 0; the data outputs are don't-care but are driven to 0.
REQ-028 Flush priority: flush_i = 1 at an edge -> next state EMPTY, and any simultaneous accept is discarded.
REQ-029 The delivered flag is not generated during flush; MEM sees mem_valid_o = 0 in the cycle after the flush.
REQ-030 ex_valid_i while ex_ready_o = 0 has no effect; EX holds its payload.

Reset
REQ-031 rst = 1 forces EMPTY immediately, regardless of clk.
REQ-032 Reset values: occupancy_o = 0, mem_valid_o = 0, ex_ready_o = 1, and all payload outputs and skid contents = 0.
REQ-033 Reset asserted mid-transfer discards all entries; the first accept after rst deasserts behaves as from EMPTY.

Configuration
REQ-034 Macro EX_MEM_SKID_EN defined: two-entry skid behaviour per REQ-018..REQ-022.
REQ-035 Macro EX_MEM_SKID_EN undefined: skid register removed and state limited to EMPTY/ONE.
REQ-036 Without the macro, ex_ready_o = !mem_valid_o || mem_ready_i (combinational), and occupancy_o never exceeds 1.
REQ-037 Without the macro, all other requirements apply unchanged.

Verification
REQ-038 Reset, then ex_valid_i = 1, alu_result_i = 0x00001000, rd_i = 5, control_flow_i = 4'b1000, mem_ready_i = 1 -> next cycle mem_valid_o = 1, alu_result_o = 0x00001000, rd_o = 5, control_flow_o = 4'b1000.
REQ-039 mem_ready_i = 0 and two accepts A = 0x11, B = 0x22 -> occupancy_o = 2, ex_ready_o = 0, output holds A. Raise mem_ready_i -> A then B delivered on consecutive cycles, then occupancy_o = 0.
REQ-040 Back-to-back stream of 8 values 0..7 with mem_ready_i toggling 1,0,1,0 -> MEM receives exactly 0..7 in order with no duplicates.
REQ-041 In state TWO, flush_i = 1 together with ex_valid_i = 1 -> next cycle mem_valid_o = 0, occupancy_o = 0, control_flow_o = 0.
REQ-042 With an entry held and mem_ready_i = 0, assert rst asynchronously between edges -> mem_valid_o = 0 and ex_ready_o = 1 immediately.
REQ-043 Build without EX_MEM_SKID_EN: full with mem_ready_i = 1 -> ex_ready_o = 1 in the same cycle, and occupancy_o never equals 2.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a valid/ready handshake on both sides.
// With EX_MEM_SKID_EN defined, a second (skid) entry lets ex_ready_o be a
// registered signal; without it, the block holds a single entry and
// ex_ready_o is derived combinationally from mem_ready_i.
// Payload outputs show the head entry and are forced to zero when no entry
// is presented, so MEM sees a clean bubble.
module ex_mem_skid #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] rd2_data_i,
    input  logic [RD_WIDTH-1:0]   rd_i,
    input  logic [CTRL_WIDTH-1:0] control_flow_i,
    input  logic                  flush_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [DATA_WIDTH-1:0] rd2_data_o,
    output logic [RD_WIDTH-1:0]   rd_o,
    output logic [CTRL_WIDTH-1:0] control_flow_o,
    output logic [1:0]            occupancy_o
);

    localparam int PW = 2 * DATA_WIDTH + RD_WIDTH + CTRL_WIDTH;

    // Encodings double as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] in_payload;
    logic          accept;
    logic          deliver;

    assign in_payload = {alu_result_i, rd2_data_i, rd_i, control_flow_i};

    // A flush suppresses both handshakes so no entry is consumed or taken.
    assign accept  = ex_valid_i && ex_ready_o && !flush_i;
    assign deliver = mem_valid_o && mem_ready_i && !flush_i;

`ifdef EX_MEM_SKID_EN
    logic [PW-1:0] skid_q, skid_d;
    logic          ready_q;

    // Next state and entry movement for the two-entry buffer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_d = in_payload;
                    end else if (accept) begin
                        skid_d  = in_payload;
                        state_d = ST_TWO;
                    end else if (deliver) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Ready is low here, so only the head can leave.
                    if (deliver) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Ready is registered from the next state: low only while both slots are full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    assign ex_ready_o = ready_q;
`else
    // Next state and entry movement for the single-entry register.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    // Accept implies deliver here, since ready follows mem_ready_i.
                    if (accept) begin
                        main_d = in_payload;
                    end else if (deliver) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign ex_ready_o = !mem_valid_o || mem_ready_i;
`endif

    // State and head-entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    assign mem_valid_o = (state_q != ST_EMPTY);
    assign occupancy_o = state_q;

    // Head payload, zeroed into a bubble when nothing is presented.
    always_comb begin
        alu_result_o   = '0;
        rd2_data_o     = '0;
        rd_o           = '0;
        control_flow_o = '0;
        if (mem_valid_o) begin
            {alu_result_o, rd2_data_o, rd_o, control_flow_o} = main_q;
        end
    end

endmodule
